regfile_sb: RTL and testbench

Parametrised multi-port register file with an integrated scoreboard, for the pipelined RiSC-16 core and wider variants.
- Provides `p_READ_PORTS` asynchronous read ports and two prioritised write ports.
- Forwards same-cycle writes to readers (write-through bypass).
- Tracks one pending bit per register, set when a producer issues and cleared when it writes back.
- Sits between decode (reads, issue) and writeback (writes); `o_hazard` drives the pipeline stall logic.

---
 rtl/regfile_sb.sv | 135 +++++++++++++
 tb/tb_regfile_sb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with two prioritised write ports,
// write-through bypass to the read ports, and a per-register pending
// scoreboard that drives the decode-stage stall signal (o_hazard).
// Register 0 is hardwired to zero and is never pending.
module regfile_sb #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_REG_ADDR_LEN  = 3,
    parameter int p_REG_FILE_SIZE = 8,
    parameter int p_READ_PORTS    = 2
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [p_READ_PORTS-1:0]                i_rd_en,
    input  logic [p_READ_PORTS*p_REG_ADDR_LEN-1:0] i_rd_addr,
    output logic [p_READ_PORTS*p_WORD_LEN-1:0]     o_rd_data,
    output logic [p_READ_PORTS-1:0]                o_rd_ready,
    output logic                                   o_hazard,
    input  logic [1:0]                             i_wr_en,
    input  logic [2*p_REG_ADDR_LEN-1:0]            i_wr_addr,
    input  logic [2*p_WORD_LEN-1:0]                i_wr_data,
    input  logic                                   i_issue_en,
    input  logic [p_REG_ADDR_LEN-1:0]              i_issue_tgt,
    input  logic                                   i_flush,
    output logic [p_REG_FILE_SIZE-1:0]             o_pending
);

    localparam int W = p_WORD_LEN;
    localparam int A = p_REG_ADDR_LEN;
    localparam int S = p_REG_FILE_SIZE;

    // Architectural state
    logic [W-1:0] regs_q [S];
    logic [W-1:0] regs_d [S];
    logic [S-1:0] pend_q;
    logic [S-1:0] pend_d;

    // Unpacked write ports
    logic [A-1:0] wr_addr_0;
    logic [A-1:0] wr_addr_1;
    logic [W-1:0] wr_data_0;
    logic [W-1:0] wr_data_1;
    logic         wr_eff_0;
    logic         wr_eff_1;

    // One-hot register selects for writes and issue (bit 0 never set)
    logic [S-1:0] wr_hot_0;
    logic [S-1:0] wr_hot_1;
    logic [S-1:0] issue_hot;

    assign wr_addr_0 = i_wr_addr[0 +: A];
    assign wr_addr_1 = i_wr_addr[A +: A];
    assign wr_data_0 = i_wr_data[0 +: W];
    assign wr_data_1 = i_wr_data[W +: W];

    // A write to register 0 is not a write at all: it neither stores nor bypasses
    assign wr_eff_0 = i_wr_en[0] & (wr_addr_0 != '0);
    assign wr_eff_1 = i_wr_en[1] & (wr_addr_1 != '0);

    assign wr_hot_0  = wr_eff_0 ? (S'(1) << wr_addr_0) : '0;
    assign wr_hot_1  = wr_eff_1 ? (S'(1) << wr_addr_1) : '0;
    assign issue_hot = (i_issue_en && (i_issue_tgt != '0)) ? (S'(1) << i_issue_tgt) : '0;

    // Next register contents: port 1 overrides port 0 on a shared target
    always_comb begin
        for (int r = 0; r < S; r++) begin
            regs_d[r] = regs_q[r];
            if (wr_hot_1[r]) begin
                regs_d[r] = wr_data_1;
            end else if (wr_hot_0[r]) begin
                regs_d[r] = wr_data_0;
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state: flush clears all; a new issue outranks a retiring writeback
    always_comb begin
        if (i_flush) begin
            pend_d = '0;
        end else begin
            pend_d = (pend_q & ~(wr_hot_0 | wr_hot_1)) | issue_hot;
        end
        pend_d[0] = 1'b0;
    end

    // State registers, cleared immediately on reset so in-flight writes and issues are dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < S; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int r = 0; r < S; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pend_q <= pend_d;
        end
    end

    assign o_pending = pend_q;

    genvar gi;
    generate
        for (gi = 0; gi < p_READ_PORTS; gi++) begin : g_rd
            logic [A-1:0] addr;
            logic [W-1:0] data;
            logic         ready;

            assign addr = i_rd_addr[gi*A +: A];

            // Read mux: zero register, then bypass (port 1 first), then storage gated by pending
            always_comb begin
                data  = regs_q[addr];
                ready = ~pend_q[addr];
                if (addr == '0) begin
                    data  = '0;
                    ready = 1'b1;
                end else if (wr_eff_1 && (wr_addr_1 == addr)) begin
                    data  = wr_data_1;
                    ready = 1'b1;
                end else if (wr_eff_0 && (wr_addr_0 == addr)) begin
                    data  = wr_data_0;
                    ready = 1'b1;
                end
            end

            assign o_rd_data[gi*W +: W] = data;
            assign o_rd_ready[gi]       = ready;
        end
    endgenerate

    assign o_hazard = |(i_rd_en & ~o_rd_ready);

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb. The driver applies one
// transaction per cycle, predicts the combinational response from a
// behavioural model and queues it; the monitor pops and compares at the
// following negedge.
module tb_regfile_sb #(
    parameter int W = 16,
    parameter int A = 3,
    parameter int R = 3
);
    localparam int S = 2**A;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [R-1:0]       i_rd_en = '0;
    logic [R*A-1:0]     i_rd_addr = '0;
    logic [R*W-1:0]     o_rd_data;
    logic [R-1:0]       o_rd_ready;
    logic               o_hazard;
    logic [1:0]         i_wr_en = '0;
    logic [2*A-1:0]     i_wr_addr = '0;
    logic [2*W-1:0]     i_wr_data = '0;
    logic               i_issue_en = 1'b0;
    logic [A-1:0]       i_issue_tgt = '0;
    logic               i_flush = 1'b0;
    logic [S-1:0]       o_pending;

    always #5 clk = ~clk;

    regfile_sb #(
        .p_WORD_LEN(W),
        .p_REG_ADDR_LEN(A),
        .p_REG_FILE_SIZE(S),
        .p_READ_PORTS(R)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rd_en(i_rd_en),
        .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data),
        .o_rd_ready(o_rd_ready),
        .o_hazard(o_hazard),
        .i_wr_en(i_wr_en),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .i_issue_en(i_issue_en),
        .i_issue_tgt(i_issue_tgt),
        .i_flush(i_flush),
        .o_pending(o_pending)
    );

    typedef struct {
        string        nm;
        int           id;
        logic [R*W-1:0] data;
        logic [R-1:0] rdy;
        logic         hz;
        logic [S-1:0] pend;
    } exp_t;

    exp_t q[$];

    // Reference model: architectural register values and outstanding producers
    logic [W-1:0] mem [S];
    logic [S-1:0] pend;

    int total = 0;
    int bad   = 0;
    int n_txn = 0;

    // One cycle of stimulus; rst asserts reset between edges, after the inputs are applied
    task automatic cyc(input string nm, input logic [A-1:0] ra,
                       input logic [1:0] wen,
                       input logic [A-1:0] wa0, input logic [W-1:0] wd0,
                       input logic [A-1:0] wa1, input logic [W-1:0] wd1,
                       input logic iss, input logic [A-1:0] tgt,
                       input logic fl, input logic rst);
        exp_t         e;
        logic [W-1:0] nxt [S];
        logic [S-1:0] wr;
        logic [A-1:0] a;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < R; k++) begin
            a = (k == 0) ? ra : A'($urandom_range(S-1, 0));
            i_rd_addr[k*A +: A] = a;
        end
        i_rd_en     = R'($urandom) | R'(1);
        i_wr_en     = wen;
        i_wr_addr   = {wa1, wa0};
        i_wr_data   = {wd1, wd0};
        i_issue_en  = iss;
        i_issue_tgt = tgt;
        i_flush     = fl;
        if (rst) begin
            #1;
            rst_n = 1'b0;
            for (int r = 0; r < S; r++) mem[r] = '0;
            pend = '0;
        end
        // A read sees the register as it will be after this cycle's writes
        nxt = mem;
        wr  = '0;
        if (wen[0] && wa0 != '0) begin nxt[wa0] = wd0; wr[wa0] = 1'b1; end
        if (wen[1] && wa1 != '0) begin nxt[wa1] = wd1; wr[wa1] = 1'b1; end
        e.nm   = nm;
        e.id   = n_txn;
        n_txn++;
        e.pend = pend;
        e.hz   = 1'b0;
        for (int k = 0; k < R; k++) begin
            a = i_rd_addr[k*A +: A];
            e.data[k*W +: W] = wr[a] ? nxt[a] : mem[a];
            e.rdy[k]         = wr[a] | ~pend[a];
            e.hz             = e.hz | (i_rd_en[k] & ~e.rdy[k]);
        end
        q.push_back(e);
        if (!rst) begin
            for (int r = 0; r < S; r++) mem[r] = nxt[r];
            if (fl) begin
                pend = '0;
            end else begin
                pend = pend & ~wr;
                if (iss && tgt != '0) pend[tgt] = 1'b1;
            end
        end
    endtask

    task automatic rd(input string nm, input logic [A-1:0] ra);
        cyc(nm, ra, 2'b00, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr0(input string nm, input logic [A-1:0] ra, input logic [A-1:0] wa, input logic [W-1:0] wd);
        cyc(nm, ra, 2'b01, wa, wd, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic issue(input string nm, input logic [A-1:0] ra, input logic [A-1:0] tgt);
        cyc(nm, ra, 2'b00, '0, '0, '0, '0, 1'b1, tgt, 1'b0, 1'b0);
    endtask

    // Monitor: compare the queued prediction against the live outputs mid-cycle
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                ok = 1'b1;
                total += 4;
                if (o_rd_data !== e.data) begin
                    bad++; ok = 1'b0;
                    $display("FAIL %s#%0d rd_data got=%h want=%h", e.nm, e.id, o_rd_data, e.data);
                end
                if (o_rd_ready !== e.rdy) begin
                    bad++; ok = 1'b0;
                    $display("FAIL %s#%0d rd_ready got=%b want=%b", e.nm, e.id, o_rd_ready, e.rdy);
                end
                if (o_hazard !== e.hz) begin
                    bad++; ok = 1'b0;
                    $display("FAIL %s#%0d hazard got=%b want=%b", e.nm, e.id, o_hazard, e.hz);
                end
                if (o_pending !== e.pend) begin
                    bad++; ok = 1'b0;
                    $display("FAIL %s#%0d pending got=%b want=%b", e.nm, e.id, o_pending, e.pend);
                end
                $display("txn %0d %s addr=%h data=%h rdy=%b hz=%b pend=%b %s",
                         e.id, e.nm, i_rd_addr, o_rd_data, o_rd_ready, o_hazard, o_pending,
                         ok ? "ok" : "bad");
            end
        end
    end

    initial begin
        logic [A-1:0] ra, wa0, wa1, tgt;
        logic [W-1:0] wd0, wd1;
        for (int r = 0; r < S; r++) mem[r] = '0;
        pend = '0;

        // Reset state
        cyc("reset", 3'd3, 2'b00, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        cyc("reset", 3'd5, 2'b00, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Simple write/read and the zero register
        wr0("wr_r3", 3, 3, W'('h1234));
        rd("rd_r3", 3);
        wr0("wr_r0", 0, 0, W'('hFFFF));
        rd("rd_r0", 0);

        // Dual-write collision and independent dual write
        cyc("collide", 5, 2'b11, 5, W'('hAAAA), 5, W'('h5555), 1'b0, '0, 1'b0, 1'b0);
        rd("rd_r5", 5);
        cyc("dual", 2, 2'b11, 2, W'(1), 4, W'(2), 1'b0, '0, 1'b0, 1'b0);
        rd("rd_r2", 2);
        rd("rd_r4", 4);

        // Scoreboard hazard and writeback bypass
        issue("iss_r6", 6, 6);
        rd("haz_r6", 6);
        wr0("wb_r6", 6, 6, W'('h0042));
        rd("after_wb", 6);

        // Issue/writeback race
        issue("iss_r1", 1, 1);
        cyc("race", 1, 2'b01, 1, W'(7), '0, '0, 1'b1, 1, 1'b0, 1'b0);
        rd("race_chk", 1);

        // Flush with several pending, then issue to r0
        issue("iss_r2", 2, 2);
        issue("iss_r3", 3, 3);
        issue("iss_r7", 7, 7);
        cyc("flush", 7, 2'b01, 3, W'('h0033), '0, '0, 1'b0, '0, 1'b1, 1'b0);
        rd("post_flush", 3);
        issue("iss_r0", 0, 0);
        rd("post_iss_r0", 0);

        // Reset asserted mid-cycle
        wr0("wr_r4", 4, 4, W'(9));
        rd("rd_r4_9", 4);
        cyc("mid_rst", 4, 2'b00, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        rd("post_rst", 4);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            ra  = A'($urandom_range(S-1, 0));
            wa0 = A'($urandom_range(S-1, 0));
            wa1 = ($urandom_range(3, 0) == 0) ? wa0 : A'($urandom_range(S-1, 0));
            tgt = A'($urandom_range(S-1, 0));
            wd0 = W'($urandom);
            wd1 = W'($urandom);
            cyc("rand", ra, 2'($urandom), wa0, wd0, wa1, wd1,
                ($urandom_range(2, 0) == 0), tgt, ($urandom_range(19, 0) == 0), 1'b0);
        end

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain queued=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
